seq_multiplier4x4: RTL and testbench

Sequential 4x4 unsigned shift-and-add multiplier producing an 8-bit product. It sits directly around the 4-bit ripple-carry adder (`adder4bit`): it drives the adder's operand and carry-in inputs and consumes `sumv`/`cout` once per iteration. It is the first clocked arithmetic stage in the datapath and uses a start/busy/done handshake.

---
 rtl/mult_pkg.sv | 14 +
 rtl/adder4bit.sv | 23 ++
 rtl/seq_multiplier4x4.sv | 88 ++++++++
 tb/tb_seq_multiplier4x4.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and sizing for the sequential shift-and-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;
  localparam int ITERS  = 4;

endpackage

// File: rtl/adder4bit.sv
// 4-bit ripple-carry adder built from explicit full-adder cells.
module adder4bit
  import mult_pkg::*;
(
  input  logic [OP_W-1:0] av,
  input  logic [OP_W-1:0] bv,
  input  logic            cin,
  output logic [OP_W-1:0] sumv,
  output logic            cout
);

  logic [OP_W:0] w_carry;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < OP_W; i++) begin : g_fa
    assign sumv[i]      = av[i] ^ bv[i] ^ w_carry[i];
    assign w_carry[i+1] = (av[i] & bv[i]) | (w_carry[i] & (av[i] ^ bv[i]));
  end

  assign cout = w_carry[OP_W];

endmodule

// File: rtl/seq_multiplier4x4.sv
// Sequential 4x4 unsigned shift-and-add multiplier with start/busy/done handshake.
// One add-and-shift per CALC cycle through a single adder4bit instance.
module seq_multiplier4x4
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  mult_state_t       r_state;
  logic [OP_W-1:0]   r_mcand;
  logic [OP_W-1:0]   r_acc;
  logic [OP_W-1:0]   r_mplr;
  logic [1:0]        r_cnt;
  logic [PROD_W-1:0] r_product;

  logic [OP_W-1:0]   w_bv;
  logic [OP_W-1:0]   w_sumv;
  logic              w_cout;
  logic [PROD_W-1:0] w_shift;

  assign w_bv = r_mplr[0] ? r_mcand : {OP_W{1'b0}};

  adder4bit u_adder (
    .av   (r_acc),
    .bv   (w_bv),
    .cin  (1'b0),
    .sumv (w_sumv),
    .cout (w_cout)
  );

  // The adder carry is the transient accumulator bit 4; after the right
  // shift it always lands inside the stored 4-bit accumulator.
  assign w_shift = {w_cout, w_sumv, r_mplr[OP_W-1:1]};

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_mcand   <= {OP_W{1'b0}};
      r_acc     <= {OP_W{1'b0}};
      r_mplr    <= {OP_W{1'b0}};
      r_cnt     <= 2'd0;
      r_product <= {PROD_W{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand <= a;
            r_mplr  <= b;
            r_acc   <= {OP_W{1'b0}};
            r_cnt   <= 2'd0;
            r_state <= CALC;
          end else begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          {r_acc, r_mplr} <= w_shift;
          r_cnt           <= r_cnt + 2'd1;
          if (r_cnt == 2'(ITERS - 1)) begin
            r_product <= w_shift;
            r_state   <= DONE;
          end else begin
            r_state   <= CALC;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy    = (r_state != IDLE);
  assign done    = (r_state == DONE);
  assign product = r_product;

endmodule

// File: tb/tb_seq_multiplier4x4.sv
// Randomized self-checking bench for seq_multiplier4x4 against plain a*b arithmetic.
module tb_seq_multiplier4x4;
  import mult_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_multiplier4x4 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One multiply: done must appear ITERS edges after the accepting edge.
  task automatic run_mul(input int x, input int y, input bit scramble);
    int lat;
    int exp_p;
    exp_p = x * y;
    a = x[3:0];
    b = y[3:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      total++;
      if (busy !== 1'b1) begin
        bad++;
        $display("FAIL busy_calc %0d*%0d cyc=%0d got=%b want=1", x, y, lat, busy);
      end
      if (scramble) begin
        a = 4'($urandom);
        b = 4'($urandom);
      end
      tick();
      lat++;
    end
    total++;
    if (lat !== ITERS) begin
      bad++;
      $display("FAIL latency %0d*%0d got=%0d want=%0d", x, y, lat, ITERS);
    end
    total++;
    if (product !== 8'(exp_p)) begin
      bad++;
      $display("FAIL product %0d*%0d got=%0d want=%0d", x, y, product, exp_p);
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_done %0d*%0d got=%b want=1", x, y, busy);
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || product !== 8'(exp_p)) begin
      bad++;
      $display("FAIL after_done %0d*%0d done=%b busy=%b prod=%0d want 0/0/%0d",
               x, y, done, busy, product, exp_p);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    a = 4'd13;
    b = 4'd11;
    repeat (3) tick();
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
      bad++;
      $display("FAIL reset_hold busy=%b done=%b prod=%0d want 0/0/0", busy, done, product);
    end
    start = 1'b0;
    #2 rst_n = 1'b1;
    repeat (3) tick();
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
      bad++;
      $display("FAIL reset_idle busy=%b done=%b prod=%0d want 0/0/0", busy, done, product);
    end
  endtask

  task automatic test_basic();
    run_mul(13, 11, 1'b0);
    repeat (3) tick();
    total++;
    if (product !== 8'h8F) begin
      bad++;
      $display("FAIL basic_hold got=%0d want=143", product);
    end
  endtask

  task automatic test_corners();
    run_mul(15, 15, 1'b0);
    run_mul(0, 9, 1'b0);
    run_mul(9, 0, 1'b0);
    run_mul(1, 15, 1'b0);
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 256; i++) begin
      run_mul(i / 16, i % 16, 1'b1);
    end
  endtask

  // start held high: operands change mid-run, and results repeat every ITERS+2 edges.
  task automatic test_back_to_back();
    int gap;
    a = 4'd7;
    b = 4'd6;
    start = 1'b1;
    tick();
    gap = 0;
    while (done !== 1'b1 && gap < 20) begin
      a = 4'($urandom);
      b = 4'($urandom);
      tick();
      gap++;
    end
    total++;
    if (done !== 1'b1 || product !== 8'd42) begin
      bad++;
      $display("FAIL hold_start_first done=%b got=%0d want=42", done, product);
    end
    a = 4'd3;
    b = 4'd5;
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL done_width got=%b want=0", done);
    end
    gap = 1;
    while (done !== 1'b1 && gap < 20) begin
      tick();
      gap++;
    end
    total++;
    if (gap !== ITERS + 2) begin
      bad++;
      $display("FAIL b2b_period got=%0d want=%0d", gap, ITERS + 2);
    end
    total++;
    if (product !== 8'd15) begin
      bad++;
      $display("FAIL b2b_product got=%0d want=15", product);
    end
    start = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    a = 4'd5;
    b = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_busy got=%b want=1", busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
      bad++;
      $display("FAIL mid_reset busy=%b done=%b prod=%0d want 0/0/0", busy, done, product);
    end
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL mid_no_done got=%0d active cycles want=0", seen);
    end
    run_mul(3, 4, 1'b0);
  endtask

  initial begin
    start = 1'b0;
    a = 4'd0;
    b = 4'd0;
    rst_n = 1'b0;
    test_reset();
    test_basic();
    test_corners();
    test_sweep();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
